// File: rtl/alu_share_arbiter.sv
// Shares one combinational 32-bit ALU between two valid/ready requesters; result is registered and held for its owner.
// Optional round-robin arbitration under `ifdef ALU_ARB_RR_EN (fixed priority to requester 0 otherwise).
module alu_share_arbiter #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [DW-1:0] req_a0,
    input  logic [DW-1:0] req_b0,
    input  logic [DW-1:0] req_a1,
    input  logic [DW-1:0] req_b1,
    input  logic [3:0]    req_sel0,
    input  logic [3:0]    req_sel1,
    output logic [1:0]    rsp_valid,
    input  logic [1:0]    rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          busy
);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t        r_state;
    logic          r_owner;
    logic [1:0]    r_rsp_valid;
    logic [DW-1:0] r_rsp_data;
    logic          r_rsp_err;
`ifdef ALU_ARB_RR_EN
    logic          r_last;
`endif

    logic          w_g;
    logic          w_can_issue;
    logic          w_accept;
    logic [DW-1:0] w_a;
    logic [DW-1:0] w_b;
    logic [3:0]    w_sel;

    function automatic logic is_illegal(input logic [3:0] sel);
        return (sel == 4'b1110) || (sel == 4'b1111);
    endfunction

    // Shift amounts always come from b[4:0]; illegal selects fall to zero.
    function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [3:0] sel);
        logic signed [DW-1:0] sa;
        logic signed [DW-1:0] sb;
        logic [4:0]           sh;
        sa = a;
        sb = b;
        sh = b[4:0];
        case (sel)
            4'b0001: return a + b;
            4'b0010: return a - b;
            4'b0011, 4'b1011: return a << sh;
            4'b0100: return {{(DW-1){1'b0}}, (sa < sb)};
            4'b0101: return {{(DW-1){1'b0}}, (a < b)};
            4'b0110: return a ^ b;
            4'b0111, 4'b1100: return a >> sh;
            4'b1000, 4'b1101: return sa >>> sh;
            4'b1001: return a | b;
            4'b1010: return a & b;
            default: return '0;
        endcase
    endfunction

    always_comb begin
        w_g = 1'b0;
        case (req_valid)
            2'b10:   w_g = 1'b1;
`ifdef ALU_ARB_RR_EN
            2'b11:   w_g = ~r_last;
`else
            2'b11:   w_g = 1'b0;
`endif
            default: w_g = 1'b0;
        endcase
        w_a   = w_g ? req_a1   : req_a0;
        w_b   = w_g ? req_b1   : req_b0;
        w_sel = w_g ? req_sel1 : req_sel0;
    end

    assign w_can_issue = (r_state == S_IDLE) || ((r_state == S_HOLD) && rsp_ready[r_owner]);
    assign req_ready   = w_can_issue ? (req_valid & (w_g ? 2'b10 : 2'b01)) : 2'b00;
    assign w_accept    = |req_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_owner     <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
`ifdef ALU_ARB_RR_EN
            r_last      <= 1'b1;
`endif
        end else if (w_accept) begin
            r_state     <= S_HOLD;
            r_owner     <= w_g;
            r_rsp_valid <= w_g ? 2'b10 : 2'b01;
            r_rsp_data  <= alu_f(w_a, w_b, w_sel);
            r_rsp_err   <= is_illegal(w_sel);
`ifdef ALU_ARB_RR_EN
            r_last      <= w_g;
`endif
        end else if ((r_state == S_HOLD) && rsp_ready[r_owner]) begin
            // Drain keeps data/err so the last result stays observable.
            r_state     <= S_IDLE;
            r_rsp_valid <= 2'b00;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_state == S_HOLD);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter; contention expectations follow ALU_ARB_RR_EN.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rstn;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [3:0]  req_sel0, req_sel1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    alu_share_arbiter #(.DW(32)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_sel0(req_sel0), .req_sel1(req_sel1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        req_sel0 = '0; req_sel1 = '0;
        #3;
        checks++;
        if (rsp_valid !== 2'b00 || rsp_data !== 32'h0 || rsp_err !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b00) begin
            failures++;
            $display("FAIL reset_state: valid=%b data=%h err=%b busy=%b rdy=%b, expected 00/0/0/0/00",
                     rsp_valid, rsp_data, rsp_err, busy, req_ready);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: valid=%b busy=%b, expected 00/0", rsp_valid, busy);
        end
    endtask

    task automatic test_add();
        @(negedge clk);
        req_valid = 2'b01; req_a0 = 32'd4; req_b0 = 32'd4; req_sel0 = 4'b0001; rsp_ready = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL add_req_ready: got %b expected 01", req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'd8 || rsp_err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL add_result: valid=%b data=%h err=%b busy=%b, expected 01/8/0/1",
                     rsp_valid, rsp_data, rsp_err, busy);
        end
        @(negedge clk);
        req_valid = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_data !== 32'd8) begin
            failures++;
            $display("FAIL add_drain: valid=%b busy=%b data=%h, expected 00/0/8", rsp_valid, busy, rsp_data);
        end
    endtask

    task automatic test_contention();
        logic [1:0]  exp_rdy;
        logic [31:0] exp_data;
        apply_reset();
        req_a0 = 32'd10; req_b0 = 32'd3; req_sel0 = 4'b0010;
        req_a1 = 32'd5;  req_b1 = 32'd3; req_sel1 = 4'b0110;
        rsp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            req_valid = 2'b11;
`ifdef ALU_ARB_RR_EN
            exp_rdy  = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_data = (i % 2 == 0) ? 32'd7 : 32'd6;
`else
            exp_rdy  = 2'b01;
            exp_data = 32'd7;
`endif
            #1;
            checks++;
            if (req_ready !== exp_rdy) begin
                failures++;
                $display("FAIL contend_grant%0d: got %b expected %b", i, req_ready, exp_rdy);
            end
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== exp_rdy || rsp_data !== exp_data || rsp_err !== 1'b0) begin
                failures++;
                $display("FAIL contend_result%0d: valid=%b data=%h err=%b, expected %b/%h/0",
                         i, rsp_valid, rsp_data, rsp_err, exp_rdy, exp_data);
            end
        end
        @(negedge clk);
        req_valid = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL contend_drain: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        req_valid = 2'b10; req_a1 = 32'h8000_0000; req_b1 = 32'd4; req_sel1 = 4'b1000;
        rsp_ready = 2'b00;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            failures++;
            $display("FAIL bp_req_ready1: got %b expected 10", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b01; req_a0 = 32'd1; req_b0 = 32'd2; req_sel0 = 4'b0001;
        rsp_ready = 2'b01;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            checks++;
            if (req_ready !== 2'b00 || rsp_valid !== 2'b10 || rsp_data !== 32'hF800_0000) begin
                failures++;
                $display("FAIL bp_hold%0d: rdy=%b valid=%b data=%h, expected 00/10/f8000000",
                         i, req_ready, rsp_valid, rsp_data);
            end
        end
        @(negedge clk);
        rsp_ready = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL bp_release_ready: got %b expected 01", req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'd3) begin
            failures++;
            $display("FAIL bp_release_result: valid=%b data=%h, expected 01/3", rsp_valid, rsp_data);
        end
        @(negedge clk);
        req_valid = 2'b00; rsp_ready = 2'b01;
        @(posedge clk);
    endtask

    task automatic test_alu_ops();
        logic [31:0] ta [12];
        logic [31:0] tb [12];
        logic [3:0]  ts [12];
        logic [31:0] te [12];
        logic        tr [12];
        ta = '{32'd5, -32'sd3, 32'h1, 32'hFFFF_FFFD, 32'h8000_0000, 32'hF0,
               32'hF0, 32'h1, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd9};
        tb = '{32'd6, 32'd0, 32'd4, 32'd0, 32'd4, 32'h0F,
               32'h3C, 32'h21, 32'd4, 32'd4, 32'd5, 32'd9};
        ts = '{4'b1111, 4'b0100, 4'b0011, 4'b0101, 4'b0111, 4'b1001,
               4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b0000, 4'b1110};
        te = '{32'h0, 32'h1, 32'h10, 32'h0, 32'h0800_0000, 32'hFF,
               32'h30, 32'h2, 32'h0800_0000, 32'hF800_0000, 32'h0, 32'h0};
        tr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            req_valid = 2'b01; req_a0 = ta[i]; req_b0 = tb[i]; req_sel0 = ts[i];
            rsp_ready = (i == 0) ? 2'b00 : 2'b01;
            #1;
            checks++;
            if (req_ready !== 2'b01) begin
                failures++;
                $display("FAIL alu_ready_sel%b: got %b expected 01", ts[i], req_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 2'b01 || rsp_data !== te[i] || rsp_err !== tr[i]) begin
                failures++;
                $display("FAIL alu_sel%b: valid=%b data=%h err=%b, expected 01/%h/%b",
                         ts[i], rsp_valid, rsp_data, rsp_err, te[i], tr[i]);
            end
        end
        @(negedge clk);
        req_valid = 2'b00; rsp_ready = 2'b01;
        @(posedge clk);
    endtask

    task automatic test_reset_mid_hold();
        @(negedge clk);
        req_valid = 2'b01; req_a0 = 32'd4; req_b0 = 32'd4; req_sel0 = 4'b0001; rsp_ready = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'd8) begin
            failures++;
            $display("FAIL midrst_hold: valid=%b data=%h, expected 01/8", rsp_valid, rsp_data);
        end
        @(negedge clk);
        req_valid = 2'b00;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 2'b00 || rsp_data !== 32'h0 || busy !== 1'b0 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async: valid=%b data=%h busy=%b err=%b, expected 00/0/0/0",
                     rsp_valid, rsp_data, busy, rsp_err);
        end
        @(negedge clk);
        rstn = 1'b1;
        req_a0 = 32'd10; req_b0 = 32'd3; req_sel0 = 4'b0010;
        req_a1 = 32'd5;  req_b1 = 32'd3; req_sel1 = 4'b0110;
        req_valid = 2'b11; rsp_ready = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL midrst_first_grant: got %b expected 01", req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'd7) begin
            failures++;
            $display("FAIL midrst_first_result: valid=%b data=%h, expected 01/7", rsp_valid, rsp_data);
        end
        @(negedge clk);
        req_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_add();
        test_contention();
        test_backpressure();
        test_alu_ops();
        test_reset_mid_hold();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequences one shared 32-bit ALU between two requesters, such as the pipeline EX stage and an address/branch-target unit. Each requester has a valid/ready request channel and a valid/ready response channel. The block grants the ALU to one requester per cycle, registers the result, and holds it for the owner until the owner accepts it. One operation is in flight at a time, and a new request may issue in the same cycle the previous result drains.

## Interface
- DW, 32, operand/result width; must be 32 (sel semantics assume 5-bit shamt).
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request valid, bit i = requester i
- req_ready  out  2  per-requester request accept
- req_a0, req_b0  in  DW  requester 0 operands
- req_a1, req_b1  in  DW  requester 1 operands
- req_sel0, req_sel1  in  4  ALU select, team encoding 0000..1101
- rsp_valid  out  2  result valid for requester i (at most one bit set)
- rsp_ready  in  2  requester i accepts result
- rsp_data  out  DW  registered result, shared by both requesters
- rsp_err  out  1  held result came from an illegal sel (1110/1111)
- busy  out  1  a result is held (state HOLD)

## Operation
- Internal combinational ALU uses the team 4-bit sel encoding:
  - 0000 zero, 0001 add, 0010 sub, 0011 sll by b.
  - 0100 slt signed, 0101 sltu.
  - 0110 xor, 0111 srl by b, 1000 sra by b.
  - 1001 or, 1010 and.
  - 1011/1100/1101 slli/srli/srai by b[4:0].
- Illegal sel 1110/1111 produces rsp_data = 0 and rsp_err = 1. It never produces X.
- FSM states:
  - IDLE: nothing held.
  - HOLD: result held for owner o. rsp_valid[o] = 1.
- can_issue = (state == IDLE) || (state == HOLD && rsp_ready[o]).
- Arbitration picks g from req_valid.
  - If only one bit is set, g is that requester.
  - If both are set, the rule depends on configuration.
- req_ready[g] = can_issue && req_valid[g]. The other requester's req_ready bit is 0. Both bits are 0 when !can_issue.
- Accept (req_valid[g] && req_ready[g]):
  - rsp_data <= ALU(a_g, b_g, sel_g), rsp_err <= illegal(sel_g), o <= g, state <= HOLD.
- Drain without a new accept (HOLD, rsp_ready[o], no accept): state <= IDLE. rsp_data and rsp_err keep their value.
- Drain plus accept in the same cycle: the new result overwrites, and the state stays HOLD with the new owner.
- rsp_ready[~o] is ignored. rsp_ready in IDLE is ignored.
- A requester must hold req_* stable while req_valid is high and not accepted. The block does not check this.

## Timing
- Reset (async assert, sync-safe deassert on next edge):
  - state = IDLE, rsp_valid = 00, rsp_data = 0, rsp_err = 0, busy = 0, req_ready = 00.
  - Round-robin pointer last = 1, so requester 0 wins first.
- Latency: accept edge N gives rsp_valid and rsp_data at edge N (visible in cycle N+1). That is 1 cycle from request to result.
- Throughput: 1 op/cycle when the owner holds rsp_ready high continuously. Backpressure holds the result indefinitely.
- req_ready is combinational from state, o, rsp_ready and req_valid. It has no combinational path from operands.
- Reset mid-HOLD: the held result is discarded, and rsp_valid drops asynchronously.

## Configuration
- ALU_ARB_RR_EN defined:
  - Round-robin. On a contention, g = ~last.
  - last <= g on every accept, including uncontended ones.
- ALU_ARB_RR_EN undefined:
  - Fixed priority. Requester 0 always wins a contention.
  - The last register is not implemented.

## Test plan
- Reset, then req0 add a=4,b=4 with rsp_ready0=1:
  - req_ready=01.
  - Next cycle rsp_valid=01, rsp_data=8, rsp_err=0.
- Both requesters valid for 4 cycles, req0 sub(10,3), req1 xor(5,3), both rsp_ready=1:
  - With ALU_ARB_RR_EN: grants alternate 0,1,0,1, results 7,6,7,6.
  - Without ALU_ARB_RR_EN: grants 0,0,0,0.
- req1 sra a=0x80000000,b=4 with rsp_ready1=0 for 3 cycles:
  - rsp_valid=10 and rsp_data=0xF8000000 stay stable.
  - req_ready=00 while req0 is valid.
  - When rsp_ready1=1, req0 is accepted in the same cycle.
- req0 sel=1111: rsp_data=0, rsp_err=1.
- Next req0 slt a=-3,b=0: rsp_data=1, rsp_err=0.
- rstn pulsed low while HOLD with rsp_valid=01:
  - rsp_valid=00 and rsp_data=0 immediately.
  - After release, requester 0 wins the first contention.
